// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU memory-port arbiter: FSM states, port identities and data width.
package cpu_mem_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;
    typedef enum logic {REQ_IF, REQ_DM} arb_req_e;

    localparam int WORD_W = 32;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency memory between the fetch (IF) and data (DM) ports.
// DM has priority; a starvation counter forces an IF grant after STARVE_MAX DM grants.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int LATENCY    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [WORD_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [3:0]        dm_we,
    input  logic [WORD_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [WORD_W-1:0] dm_rdata,
    output logic              mem_cs,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);

    localparam int LAT_W    = $clog2(LATENCY + 1);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    arb_state_e          state;
    arb_req_e            owner;
    logic                owner_wr;
    logic [LAT_W-1:0]    lat_cnt;
    logic [STARVE_W-1:0] starve_cnt;

    logic done;
    logic can_grant;
    logic starved;
    logic if_win;
    logic dm_win;

    // The response cycle doubles as an idle cycle, so a new grant can overlap it.
    assign done      = (state == ARB_BUSY) && (lat_cnt == '0);
    assign can_grant = !rst && ((state == ARB_IDLE) || done);
    assign starved   = (starve_cnt == STARVE_W'(STARVE_MAX));

    assign if_win = can_grant && if_req && (!dm_req || starved);
    assign dm_win = can_grant && dm_req && !if_win;

    assign if_gnt    = if_win;
    assign dm_gnt    = dm_win;
    assign mem_cs    = if_win || dm_win;
    assign mem_we    = dm_win ? dm_we : 4'b0000;
    assign mem_addr  = dm_win ? dm_addr : (if_win ? if_addr : '0);
    assign mem_wdata = dm_win ? dm_wdata : '0;

    assign if_rvalid = done && (owner == REQ_IF);
    assign dm_rvalid = done && (owner == REQ_DM);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = (dm_rvalid && !owner_wr) ? mem_rdata : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_IDLE;
            owner      <= REQ_IF;
            owner_wr   <= 1'b0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
        end else begin
            if (if_win || dm_win) begin
                state    <= ARB_BUSY;
                owner    <= dm_win ? REQ_DM : REQ_IF;
                owner_wr <= dm_win && (dm_we != 4'b0000);
                lat_cnt  <= LAT_W'(LATENCY - 1);
            end else if (done) begin
                state <= ARB_IDLE;
            end else if (state == ARB_BUSY) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end

            if (if_win) begin
                starve_cnt <= '0;
            end else if (dm_win) begin
                if (!if_req)
                    starve_cnt <= '0;
                else if (!starved)
                    starve_cnt <= starve_cnt + STARVE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 2-cycle-latency memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic [15:0] dm_addr;
    logic [3:0]  dm_we;
    logic [31:0] dm_wdata;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_cs;
    logic [3:0]  mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:16383];
    logic [31:0] pipe1, pipe2;

    logic [31:0] ig_v, dg_v, ir_v, dr_v, cs_v, we_v;
    logic [31:0] ir_d [0:31];
    logic [31:0] dr_d [0:31];
    logic [15:0] ad_v [0:31];
    logic [1:0]  st_v [0:31];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(16), .LATENCY(2), .STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_addr(dm_addr), .dm_we(dm_we), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory model: data read on a strobe appears two cycles later.
    always @(posedge clk) begin
        if (mem_cs) begin
            pipe1 <= mem[mem_addr[15:2]];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr[15:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end else begin
            pipe1 <= 32'h0;
        end
        pipe2 <= pipe1;
    end
    assign mem_rdata = pipe2;

    // Runs n cycles from posedge+1, sampling at each negedge; optionally drops a request once granted.
    task automatic run(input int n, input bit drop_if, input bit drop_dm);
        bit di, dd;
        ig_v = '0; dg_v = '0; ir_v = '0; dr_v = '0; cs_v = '0; we_v = '0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            ig_v[c] = if_gnt;
            dg_v[c] = dm_gnt;
            ir_v[c] = if_rvalid;
            dr_v[c] = dm_rvalid;
            cs_v[c] = mem_cs;
            we_v[c] = (mem_we != 4'b0000);
            ir_d[c] = if_rdata;
            dr_d[c] = dm_rdata;
            ad_v[c] = mem_addr;
            st_v[c] = dut.starve_cnt;
            di = drop_if && if_gnt;
            dd = drop_dm && dm_gnt;
            @(posedge clk);
            #1;
            if (di) if_req = 1'b0;
            if (dd) dm_req = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_req = 1'b1; if_addr = 16'h0100;
        dm_req = 1'b0; dm_addr = 16'h0; dm_we = 4'b0; dm_wdata = 32'h0;
        #2;
        n_cmp++;
        if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_cs, mem_we} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b, want 0", {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_cs, mem_we});
        end
        n_cmp++;
        if ({if_rdata, dm_rdata} !== 64'h0) begin
            n_err++;
            $display("FAIL reset_rdata: got %h %h, want 0", if_rdata, dm_rdata);
        end
        if_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        dm_req = 1'b1; dm_addr = 16'h0100; dm_we = 4'b0;
        @(negedge clk);
        n_cmp++;
        if (dm_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL rstbusy_gnt: got %b, want 1", dm_gnt);
        end
        @(posedge clk); #1;
        dm_req = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_cs, mem_we, if_rdata, dm_rdata} !== 73'b0) begin
            n_err++;
            $display("FAIL rstbusy_outs: got %h, want 0", {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_cs, mem_we, if_rdata, dm_rdata});
        end
        run(4, 1, 1);
        n_cmp++;
        if ({dr_v[3:0], cs_v[3:0]} !== 8'b0) begin
            n_err++;
            $display("FAIL rstbusy_quiet: rvalid/cs got %b, want 0", {dr_v[3:0], cs_v[3:0]});
        end
        rst = 1'b0;
        dm_req = 1'b1;
        run(4, 1, 1);
        n_cmp++;
        if ({dg_v[3:0], dr_v[3:0]} !== 8'b0001_0100) begin
            n_err++;
            $display("FAIL rstbusy_regrant: gnt/rvalid got %b, want 00010100", {dg_v[3:0], dr_v[3:0]});
        end
        n_cmp++;
        if (dr_d[2] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL rstbusy_rdata: got %h, want deadbeef", dr_d[2]);
        end
    endtask

    task automatic test_lone_fetch();
        bit dm_any;
        if_req = 1'b1; if_addr = 16'h0100;
        run(6, 1, 1);
        n_cmp++;
        if ({ig_v[5:0], cs_v[5:0], ir_v[5:0]} !== 18'b000001_000001_000100) begin
            n_err++;
            $display("FAIL fetch_timing: gnt/cs/rvalid got %b, want 000001000001000100", {ig_v[5:0], cs_v[5:0], ir_v[5:0]});
        end
        n_cmp++;
        if (ir_d[2] !== 32'hDEADBEEF || ad_v[0] !== 16'h0100) begin
            n_err++;
            $display("FAIL fetch_data: rdata %h addr %h, want deadbeef 0100", ir_d[2], ad_v[0]);
        end
        dm_any = 1'b0;
        for (int c = 0; c < 6; c++) if (dr_d[c] !== 32'h0 || dg_v[c] !== 1'b0) dm_any = 1'b1;
        n_cmp++;
        if (dm_any !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_dm_quiet: dm activity got %b, want 0", dm_any);
        end
    endtask

    task automatic test_simultaneous();
        if_req = 1'b1; if_addr = 16'h0100;
        dm_req = 1'b1; dm_addr = 16'h9000; dm_we = 4'b0;
        run(8, 1, 1);
        n_cmp++;
        if ({dg_v[7:0], dr_v[7:0]} !== 16'b00000001_00000100) begin
            n_err++;
            $display("FAIL simul_dm: gnt/rvalid got %b, want 0000000100000100", {dg_v[7:0], dr_v[7:0]});
        end
        n_cmp++;
        if ({ig_v[7:0], ir_v[7:0]} !== 16'b00000100_00010000) begin
            n_err++;
            $display("FAIL simul_if: gnt/rvalid got %b, want 0000010000010000", {ig_v[7:0], ir_v[7:0]});
        end
        n_cmp++;
        if (ad_v[0] !== 16'h9000 || ad_v[2] !== 16'h0100 || ir_d[4] !== 32'hDEADBEEF || dr_d[2] !== 32'h0) begin
            n_err++;
            $display("FAIL simul_data: addr %h %h rdata %h %h, want 9000 0100 deadbeef 0", ad_v[0], ad_v[2], ir_d[4], dr_d[2]);
        end
    endtask

    task automatic test_starvation();
        if_req = 1'b1; if_addr = 16'h0100;
        dm_req = 1'b1; dm_addr = 16'h9000; dm_we = 4'b0;
        run(10, 0, 0);
        n_cmp++;
        if (dg_v[9:0] !== 10'b0100010101) begin
            n_err++;
            $display("FAIL starve_dm_gnt: got %b, want 0100010101", dg_v[9:0]);
        end
        n_cmp++;
        if (ig_v[9:0] !== 10'b0001000000) begin
            n_err++;
            $display("FAIL starve_if_gnt: got %b, want 0001000000", ig_v[9:0]);
        end
        n_cmp++;
        if (st_v[6] !== 2'd3 || st_v[7] !== 2'd0) begin
            n_err++;
            $display("FAIL starve_cnt: @6 %0d @7 %0d, want 3 0", st_v[6], st_v[7]);
        end
        if_req = 1'b0; dm_req = 1'b0;
        run(3, 1, 1);
    endtask

    task automatic test_store();
        dm_req = 1'b1; dm_addr = 16'hFFFC; dm_we = 4'b0011; dm_wdata = 32'h000000FF;
        @(negedge clk);
        n_cmp++;
        if (mem_we !== 4'b0011 || mem_wdata !== 32'h000000FF || mem_addr !== 16'hFFFC) begin
            n_err++;
            $display("FAIL store_bus: we %b wdata %h addr %h, want 0011 000000ff fffc", mem_we, mem_wdata, mem_addr);
        end
        @(posedge clk); #1;
        dm_req = 1'b0; dm_we = 4'b0; dm_wdata = 32'h0;
        run(4, 1, 1);
        n_cmp++;
        if ({we_v[3:0], dr_v[3:0]} !== 8'b0000_0010) begin
            n_err++;
            $display("FAIL store_timing: we/rvalid got %b, want 00000010", {we_v[3:0], dr_v[3:0]});
        end
        n_cmp++;
        if (dr_d[1] !== 32'h0 || mem[16'hFFFC >> 2] !== 32'h000000FF) begin
            n_err++;
            $display("FAIL store_result: rdata %h mem %h, want 0 000000ff", dr_d[1], mem[16'hFFFC >> 2]);
        end
    endtask

    task automatic test_back_to_back();
        dm_req = 1'b1; dm_addr = 16'h0100; dm_we = 4'b0;
        run(2, 1, 1);
        dm_req = 1'b1;
        run(4, 1, 1);
        n_cmp++;
        if ({dg_v[3:0], dr_v[3:0]} !== 8'b0001_0101) begin
            n_err++;
            $display("FAIL b2b_timing: gnt/rvalid got %b, want 00010101", {dg_v[3:0], dr_v[3:0]});
        end
        n_cmp++;
        if (dr_d[0] !== 32'hDEADBEEF || dr_d[2] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL b2b_data: got %h %h, want deadbeef deadbeef", dr_d[0], dr_d[2]);
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        mem[16'h0100 >> 2] = 32'hDEADBEEF;
        pipe1 = 32'h0;
        pipe2 = 32'h0;
        test_reset();
        test_reset_mid_busy();
        test_lone_fetch();
        test_simultaneous();
        test_starvation();
        test_store();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
